cpu_multicycle_control: RTL and testbench

- Moore finite-state machine (FSM) that sequences the multicycle CPU datapath.
- Consumes the 6-bit opcode latched in the instruction register and drives every datapath control strobe: PC write, IR write, register-file and memory writes, and the ALU, mux and PC-source selects.
- Also keeps retired-instruction and cycle counters, and flags halt and illegal opcodes.
- Sits directly upstream of the datapath; the two together form the CPU top.

---
 rtl/cpu_ctrl_pkg.sv | 50 +++++
 rtl/cpu_ctrl_decode.sv | 53 +++++
 rtl/cpu_multicycle_control.sv | 96 +++++++++
 tb/tb_cpu_multicycle_control.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared states, opcodes, select encodings and strobe bundle for the CPU control FSM
package cpu_ctrl_pkg;
  localparam int OPW = 6;
  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, ALU_WB, BRANCH, JUMP, HALT
  } state_t;
  localparam logic [OPW-1:0] OP_ADD  = 6'h00;
  localparam logic [OPW-1:0] OP_SUB  = 6'h01;
  localparam logic [OPW-1:0] OP_AND  = 6'h02;
  localparam logic [OPW-1:0] OP_OR   = 6'h03;
  localparam logic [OPW-1:0] OP_SLT  = 6'h04;
  localparam logic [OPW-1:0] OP_ADDI = 6'h10;
  localparam logic [OPW-1:0] OP_LW   = 6'h20;
  localparam logic [OPW-1:0] OP_SW   = 6'h21;
  localparam logic [OPW-1:0] OP_BNE  = 6'h30;
  localparam logic [OPW-1:0] OP_JMP  = 6'h31;
  localparam logic [OPW-1:0] OP_HALT = 6'h3F;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;
  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_ZERO = 2'b11;
  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       r1_or_r3;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       mem_to_reg;
    logic       mem_write;
    logic       illegal_op;
  } ctrl_t;
  function automatic logic is_rtype(input logic [OPW-1:0] op);
    return op <= OP_SLT;
  endfunction
  function automatic logic is_legal(input logic [OPW-1:0] op);
    return is_rtype(op) || op inside {OP_ADDI, OP_LW, OP_SW, OP_BNE, OP_JMP, OP_HALT};
  endfunction
endpackage

// File: rtl/cpu_ctrl_decode.sv
// cpu_ctrl_decode: combinational map from FSM state (plus opcode) to the datapath strobe bundle
// Ports: i_state current state; i_op live opcode (DECODE only); i_rop latched ALU function; o_ctrl strobes
module cpu_ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t         i_state,
  input  logic [OPW-1:0] i_op,
  input  logic [2:0]     i_rop,
  output ctrl_t          o_ctrl
);
  always_comb begin
    o_ctrl = '0;
    case (i_state)
      FETCH: begin
        o_ctrl.ir_write  = 1'b1;
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.alu_src_b = SRCB_ONE;
      end
      DECODE: begin
        o_ctrl.r1_or_r3   = 1'b1;
        o_ctrl.illegal_op = !is_legal(i_op);
      end
      EXEC_R: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_op    = i_rop;
      end
      EXEC_I, MEM_ADDR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = SRCB_IMM;
      end
      ALU_WB: o_ctrl.reg_write = 1'b1;
      MEM_WB: begin
        o_ctrl.reg_write  = 1'b1;
        o_ctrl.mem_to_reg = 1'b1;
      end
      MEM_WR: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.r1_or_r3  = 1'b1;
      end
      BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_op        = ALU_SUB;
        o_ctrl.r1_or_r3      = 1'b1;
        o_ctrl.pc_write_cond = 1'b1;
      end
      JUMP: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PCS_JUMP;
      end
      default: o_ctrl = '0;
    endcase
  end
endmodule

// File: rtl/cpu_multicycle_control.sv
// cpu_multicycle_control: Moore FSM sequencing the multicycle CPU datapath, with perf counters
// Ports: Clk, Reset (sync, active-high); Opcode from IR; PC/IR/RF/memory strobes and ALU/mux/PC selects;
//        Halted, IllegalOp status; InstrCount (retired) and CycleCount (frozen in HALT) counters.
module cpu_multicycle_control
  import cpu_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 3,
  parameter int CNT_W    = 32
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [OPCODE_W-1:0] Opcode,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                IRWrite,
  output logic                R1orR3,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic [1:0]          PCSource,
  output logic                MemtoReg,
  output logic                MemWrite,
  output logic                Halted,
  output logic                IllegalOp,
  output logic [CNT_W-1:0]    InstrCount,
  output logic [CNT_W-1:0]    CycleCount
);
  state_t              r_state, w_next;
  logic [OPCODE_W-1:0] r_op;
  logic [CNT_W-1:0]    r_instr, r_cycle;
  logic                w_retire;
  ctrl_t               w_dec, w_ctrl;

  cpu_ctrl_decode u_decode (
    .i_state (r_state),
    .i_op    (Opcode),
    .i_rop   (r_op[2:0]),
    .o_ctrl  (w_dec)
  );

  always_comb begin
    w_next = FETCH;
    case (r_state)
      FETCH:          w_next = DECODE;
      DECODE:         w_next = is_rtype(Opcode) ? EXEC_R :
                               Opcode == OP_ADDI ? EXEC_I :
                               (Opcode == OP_LW || Opcode == OP_SW) ? MEM_ADDR :
                               Opcode == OP_BNE ? BRANCH :
                               Opcode == OP_JMP ? JUMP :
                               Opcode == OP_HALT ? HALT : FETCH;
      EXEC_R, EXEC_I: w_next = ALU_WB;
      MEM_ADDR:       w_next = r_op == OP_LW ? MEM_RD : MEM_WR;
      MEM_RD:         w_next = MEM_WB;
      HALT:           w_next = HALT;
      default:        w_next = FETCH;
    endcase
  end

  // HALT retires on entry, so it is counted from DECODE rather than from a final state
  assign w_retire = (r_state inside {ALU_WB, MEM_WB, MEM_WR, BRANCH, JUMP}) ||
                    (r_state == DECODE && Opcode == OP_HALT);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= FETCH;
      r_op    <= '0;
      r_instr <= '0;
      r_cycle <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == DECODE) r_op <= Opcode;
      r_instr <= r_instr + CNT_W'(w_retire);
      if (r_state != HALT) r_cycle <= r_cycle + 1'b1;
    end
  end

  // Reset blanks every strobe combinationally so an aborted instruction cannot write in that cycle
  assign w_ctrl      = Reset ? '0 : w_dec;
  assign PCWrite     = w_ctrl.pc_write;
  assign PCWriteCond = w_ctrl.pc_write_cond;
  assign IRWrite     = w_ctrl.ir_write;
  assign R1orR3      = w_ctrl.r1_or_r3;
  assign RegWrite    = w_ctrl.reg_write;
  assign ALUSrcA     = w_ctrl.alu_src_a;
  assign ALUSrcB     = w_ctrl.alu_src_b;
  assign ALUOp       = w_ctrl.alu_op;
  assign PCSource    = w_ctrl.pc_source;
  assign MemtoReg    = w_ctrl.mem_to_reg;
  assign MemWrite    = w_ctrl.mem_write;
  assign IllegalOp   = w_ctrl.illegal_op;
  assign Halted      = r_state == HALT;
  assign InstrCount  = r_instr;
  assign CycleCount  = r_cycle;
endmodule

// File: tb/tb_cpu_multicycle_control.sv
// tb_cpu_multicycle_control: directed self-checking bench for the multicycle control FSM
module tb_cpu_multicycle_control;
  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [5:0]  Opcode = 6'h00;
  logic        PCWrite, PCWriteCond, IRWrite, R1orR3, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, PCSource;
  logic [2:0]  ALUOp;
  logic        MemtoReg, MemWrite, Halted, IllegalOp;
  logic [31:0] InstrCount, CycleCount;
  logic [16:0] w_obs;
  int errors = 0;
  int checks = 0;

  // {PCWrite,PCWriteCond,IRWrite,R1orR3,RegWrite,ALUSrcA, ALUSrcB, ALUOp, PCSource, MemtoReg,MemWrite,IllegalOp,Halted}
  localparam logic [16:0] E_ZERO   = 17'b000000_00_000_00_0000;
  localparam logic [16:0] E_FETCH  = 17'b101000_01_000_00_0000;
  localparam logic [16:0] E_DECODE = 17'b000100_00_000_00_0000;
  localparam logic [16:0] E_ILL    = 17'b000100_00_000_00_0010;
  localparam logic [16:0] E_EX_ADD = 17'b000001_00_000_00_0000;
  localparam logic [16:0] E_EX_SLT = 17'b000001_00_100_00_0000;
  localparam logic [16:0] E_EX_IMM = 17'b000001_10_000_00_0000;
  localparam logic [16:0] E_ALU_WB = 17'b000010_00_000_00_0000;
  localparam logic [16:0] E_MEM_WB = 17'b000010_00_000_00_1000;
  localparam logic [16:0] E_MEM_WR = 17'b000100_00_000_00_0100;
  localparam logic [16:0] E_BRANCH = 17'b010101_00_001_00_0000;
  localparam logic [16:0] E_JUMP   = 17'b100000_00_000_10_0000;
  localparam logic [16:0] E_HALT   = 17'b000000_00_000_00_0001;

  always #5 Clk = ~Clk;

  cpu_multicycle_control dut (
    .Clk(Clk), .Reset(Reset), .Opcode(Opcode),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IRWrite(IRWrite), .R1orR3(R1orR3),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .MemtoReg(MemtoReg), .MemWrite(MemWrite), .Halted(Halted),
    .IllegalOp(IllegalOp), .InstrCount(InstrCount), .CycleCount(CycleCount)
  );

  assign w_obs = {PCWrite, PCWriteCond, IRWrite, R1orR3, RegWrite, ALUSrcA,
                  ALUSrcB, ALUOp, PCSource, MemtoReg, MemWrite, IllegalOp, Halted};

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // Checks the strobes at the falling edge, then returns just after the next rising edge
  task automatic step(input string tag, input logic [16:0] e);
    @(negedge Clk);
    chk(tag, {15'd0, w_obs}, {15'd0, e});
    @(posedge Clk);
    #1;
  endtask

  task automatic cnt(input string tag, input int ic, input int cc);
    chk({tag, "_instr"}, InstrCount, ic);
    chk({tag, "_cycle"}, CycleCount, cc);
  endtask

  initial begin
    @(posedge Clk);
    #1;
    step("rst0", E_ZERO);
    cnt("rst0", 0, 0);
    step("rst1", E_ZERO);
    Reset = 1'b0;
    cnt("post_rst", 0, 0);
    step("fetch0", E_FETCH);
    Opcode = 6'h00;
    step("add_dec", E_DECODE);
    step("add_ex", E_EX_ADD);
    step("add_wb", E_ALU_WB);
    cnt("after_add", 1, 4);
    step("fetch1", E_FETCH);
    Opcode = 6'h04;
    step("slt_dec", E_DECODE);
    Opcode = 6'h02;
    step("slt_ex_latched", E_EX_SLT);
    step("slt_wb", E_ALU_WB);
    cnt("after_slt", 2, 8);
    step("fetch2", E_FETCH);
    Opcode = 6'h20;
    step("lw_dec", E_DECODE);
    Opcode = 6'h21;
    step("lw_addr", E_EX_IMM);
    step("lw_rd", E_ZERO);
    step("lw_wb", E_MEM_WB);
    cnt("after_lw", 3, 13);
    step("fetch3", E_FETCH);
    Opcode = 6'h21;
    step("sw_dec", E_DECODE);
    Opcode = 6'h20;
    step("sw_addr", E_EX_IMM);
    step("sw_wr", E_MEM_WR);
    cnt("after_sw", 4, 17);
    step("fetch4", E_FETCH);
    Opcode = 6'h30;
    step("bne_dec", E_DECODE);
    step("bne_br", E_BRANCH);
    cnt("after_bne", 5, 20);
    step("fetch5", E_FETCH);
    Opcode = 6'h31;
    step("jmp_dec", E_DECODE);
    step("jmp_j", E_JUMP);
    cnt("after_jmp", 6, 23);
    step("fetch6", E_FETCH);
    Opcode = 6'h15;
    step("ill_dec", E_ILL);
    cnt("after_ill", 6, 25);
    step("ill_fetch", E_FETCH);
    Opcode = 6'h10;
    step("addi_dec", E_DECODE);
    step("addi_ex", E_EX_IMM);
    step("addi_wb", E_ALU_WB);
    cnt("after_addi", 7, 29);
    step("fetch7", E_FETCH);
    Opcode = 6'h3F;
    step("halt_dec", E_DECODE);
    cnt("halt_entry", 8, 31);
    for (int i = 0; i < 20; i++) begin
      Opcode = 6'(i * 7);
      step("halt_hold", E_HALT);
    end
    cnt("halt_frozen", 8, 31);
    Reset = 1'b1;
    step("halt_rst", E_HALT);
    Reset = 1'b0;
    cnt("halt_rst", 0, 0);
    step("fetch8", E_FETCH);
    Opcode = 6'h20;
    step("lw2_dec", E_DECODE);
    step("lw2_addr", E_EX_IMM);
    Reset = 1'b1;
    step("lw2_rd_rst", E_ZERO);
    Reset = 1'b0;
    cnt("abort_rst", 0, 0);
    step("abort_fetch", E_FETCH);
    Opcode = 6'h01;
    step("sub_dec", E_DECODE);
    step("sub_ex", 17'b000001_00_001_00_0000);
    step("sub_wb", E_ALU_WB);
    cnt("after_sub", 1, 4);
    step("fetch9", E_FETCH);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
